register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the register and data width.
REQ-003 Parameter ADDR_WIDTH, default 5, SHALL set the address width, giving 2**ADDR_WIDTH registers (32 by default).
REQ-004 The block SHALL have the following ports:
  - clk  input  1  clock; all state updates on the rising edge.
  - rst  input  1  synchronous active-high reset.
  - rs1_addr  input  ADDR_WIDTH  read port 1 address.
  - rs2_addr  input  ADDR_WIDTH  read port 2 address.
  - w_en  input  1  write enable.
  - w_addr  input  ADDR_WIDTH  write address.
  - w_data  input  DATA_WIDTH  write data.
  - rs1_data  output  DATA_WIDTH  read port 1 data.
  - rs2_data  output  DATA_WIDTH  read port 2 data.

Function
REQ-005 The block SHALL hold registers x0..x31 as DATA_WIDTH-bit storage and provide two independent read ports and one write port.
REQ-006 Register x0 SHALL always read 32'h00000000 on both read ports, regardless of any write attempt.
REQ-007 On a rising clk edge with rst=0, w_en=1 and w_addr!=0, the register at w_addr SHALL be loaded with w_data.
REQ-008 Writes with w_en=0 or w_addr=0 SHALL leave all registers unchanged.
REQ-009 Reads SHALL be combinational (zero latency): rs1_data and rs2_data SHALL reflect the current contents at rs1_addr and rs2_addr within the same cycle.
REQ-010 Both read ports SHALL be allowed to address the same register simultaneously, and both SHALL return identical data.
REQ-011 A register written on edge N SHALL be readable with its new value from just after edge N onward.
REQ-012 Read-during-write to the same nonzero address SHALL follow REQ-019/REQ-020.
REQ-013 The outputs SHALL never be X after the first reset; a register never written since reset SHALL read 0.

Reset
REQ-014 On a rising clk edge with rst=1, all registers x1..x31 SHALL be cleared to 0.
REQ-015 Reset SHALL have priority over write: a write presented in a reset cycle SHALL be discarded.
REQ-016 While rst=1 and before the edge, reads SHALL return the pre-reset contents (no asynchronous clear).
REQ-017 After the reset edge, rs1_data and rs2_data SHALL be 0 for every address until a new write occurs.
REQ-018 Deasserting rst SHALL allow writes on the very next rising edge.

Configuration
REQ-019 With the macro RF_WRITE_BYPASS_EN defined, a read port SHALL return w_data combinationally when w_en=1, rst=0, w_addr!=0 and the read address equals w_addr (write-first forwarding).
REQ-020 Without RF_WRITE_BYPASS_EN, a read port SHALL return the stored (old) value during a same-address write, and the new value only after the write edge.

Verification
REQ-021 Write sequence: rst pulse, then write x1=32'h0000AAAA and x2=32'h00005555 on consecutive edges, then set w_en=0 and rs1_addr=1, rs2_addr=2 -> rs1_data=32'h0000AAAA, rs2_data=32'h00005555.
REQ-022 x0 protection: w_en=1, w_addr=0, w_data=32'hFFFFFFFF for one edge, then rs1_addr=0 -> rs1_data=32'h00000000.
REQ-023 Reset clears: write x5=32'h12345678, assert rst for one edge while w_en=1, w_addr=6, w_data=32'hDEADBEEF -> x5 and x6 both read 0 after the edge.
REQ-024 Dual-port same address: x3=32'hCAFEF00D, rs1_addr=rs2_addr=3 -> both outputs 32'hCAFEF00D.
REQ-025 Bypass: rs1_addr=7, x7 holds 0, w_en=1, w_addr=7, w_data=32'h00000055 -> before the edge rs1_data=32'h00000055 with RF_WRITE_BYPASS_EN and 0 without it; after the edge 32'h00000055 in both builds.
REQ-026 No-write hold: w_en=0 with w_addr=1 and w_data=32'h0 over several edges -> x1 retains 32'h0000AAAA.

Source files
------------

// File: rtl/register_file.sv
// Purpose : 2-read / 1-write register file, x0 hardwired to zero (compile option RF_WRITE_BYPASS_EN).
// Latency : reads are combinational (0 cycles); writes land on the rising clk edge.
// Backpr. : none; a write is accepted on every edge where w_en=1, rst=0 and w_addr!=0.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset, clears every register
//   rs1_addr/rs1_data   read port 1 (address in, data out)
//   rs2_addr/rs2_data   read port 2 (address in, data out)
//   w_en/w_addr/w_data  write port
//
// RF_WRITE_BYPASS_EN defined   : a read of the address being written returns w_data
//                                (write-first forwarding).
// RF_WRITE_BYPASS_EN undefined : the same read returns the stored (old) value until the edge.

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // Entry 0 exists only to keep the indexing simple. It is never written,
    // and reads of address 0 are forced to zero in the read mux, so its
    // contents before the first reset do not matter.
    logic [DATA_WIDTH-1:0] regs_q [NREG];

    // A write only takes effect outside reset and never to x0.
    logic wr_fire;
    assign wr_fire = w_en && !rst && (w_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[w_addr] <= w_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (addr != '0) begin
`ifdef RF_WRITE_BYPASS_EN
            // Forward the write data so a consumer sees it in the same cycle.
            if (wr_fire && (w_addr == addr)) begin
                val = w_data;
            end else begin
                val = regs_q[addr];
            end
`else
            val = regs_q[addr];
`endif
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int n_pass;
    int n_total;

    // Reference model: plain array of architectural register values.
    logic [31:0] model [32];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Value a read port should show right now, given model contents and pending write.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && w_en && !rst && (w_addr == a)) return w_data;
        return model[a];
    endfunction

    // Apply the architectural effect of the upcoming edge to the model, then take the edge.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (w_en && w_addr != 5'd0) begin
            model[w_addr] = w_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0];
            rs2_addr = 5'(31 - a);
            #1;
            n_total++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
                $display("FAIL reset_zero addr=%0d rs1=%h rs2=%h required 0", a, rs1_data, rs2_data);
            else n_pass++;
        end
    endtask

    task automatic test_write_seq();
        rst = 1'b1; step(); rst = 1'b0;
        // Write immediately on the first edge after reset deasserts.
        w_en = 1'b1; w_addr = 5'd1; w_data = 32'h0000AAAA; step();
        w_addr = 5'd2; w_data = 32'h00005555; step();
        w_en = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        n_total++;
        if (rs1_data !== 32'h0000AAAA) $display("FAIL write_seq_x1 got %h required 0000aaaa", rs1_data);
        else n_pass++;
        n_total++;
        if (rs2_data !== 32'h00005555) $display("FAIL write_seq_x2 got %h required 00005555", rs2_data);
        else n_pass++;
    endtask

    task automatic test_hold();
        w_en = 1'b0; w_addr = 5'd1; w_data = 32'h0; rs1_addr = 5'd1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_total++;
            if (rs1_data !== 32'h0000AAAA) $display("FAIL hold_x1 edge=%0d got %h required 0000aaaa", k, rs1_data);
            else n_pass++;
        end
    endtask

    task automatic test_x0();
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        n_total++;
        if (rs1_data !== 32'h0) $display("FAIL x0_during_write got %h required 0", rs1_data);
        else n_pass++;
        step();
        w_en = 1'b0;
        #1;
        n_total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
            $display("FAIL x0_after_write rs1=%h rs2=%h required 0", rs1_data, rs2_data);
        else n_pass++;
    endtask

    task automatic test_reset_clears();
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'h12345678; step();
        w_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
        #1;
        n_total++;
        if (rs1_data !== 32'h12345678) $display("FAIL rc_x5_written got %h required 12345678", rs1_data);
        else n_pass++;
        rst = 1'b1; w_en = 1'b1; w_addr = 5'd6; w_data = 32'hDEADBEEF;
        #1;
        // Reset is not asynchronous: contents survive until the edge; no forwarding under reset.
        n_total++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h0)
            $display("FAIL rc_pre_edge rs1=%h rs2=%h required 12345678/0", rs1_data, rs2_data);
        else n_pass++;
        step();
        rst = 1'b0; w_en = 1'b0;
        #1;
        n_total++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0)
            $display("FAIL rc_post_edge rs1=%h rs2=%h required 0/0", rs1_data, rs2_data);
        else n_pass++;
    endtask

    task automatic test_dual_port();
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'hCAFEF00D; step();
        w_en = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        n_total++;
        if (rs1_data !== 32'hCAFEF00D || rs2_data !== 32'hCAFEF00D)
            $display("FAIL dual_port rs1=%h rs2=%h required cafef00d", rs1_data, rs2_data);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] pre;
        pre = BYPASS ? 32'h00000055 : 32'h0;
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h00000055;
        #1;
        n_total++;
        if (rs1_data !== pre || rs2_data !== pre)
            $display("FAIL bypass_pre_edge rs1=%h rs2=%h required %h", rs1_data, rs2_data, pre);
        else n_pass++;
        step();
        w_en = 1'b0;
        #1;
        n_total++;
        if (rs1_data !== 32'h00000055) $display("FAIL bypass_post_edge got %h required 00000055", rs1_data);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 39) == 0);
            w_en   = ($urandom_range(0, 3) != 0);
            w_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            w_data = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            #1;
            n_total++;
            if (rs1_data !== exp_read(rs1_addr) || rs2_data !== exp_read(rs2_addr)) begin
                if (errs < 10)
                    $display("FAIL random cyc=%0d a1=%0d rs1=%h need %h a2=%0d rs2=%h need %h",
                             c, rs1_addr, rs1_data, exp_read(rs1_addr),
                             rs2_addr, rs2_data, exp_read(rs2_addr));
                errs++;
            end else n_pass++;
            step();
        end
        rst = 1'b0; w_en = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0; rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        test_reset();
        test_write_seq();
        test_hold();
        test_x0();
        test_dual_port();
        test_reset_clears();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
